adc_sample_bridge: RTL

Downstream consumer of the ADC serial reader. It moves each completed stereo frame (left/right words latched on the codec's LRCK edges) into the 50 MHz system domain and presents it on a valid/ready handshake to the effect and visualisation pipeline. It also reports a per-channel peak level over a fixed frame window for the level-meter display.

---
 rtl/adc_sample_bridge_pkg.sv | 25 ++
 rtl/adc_sample_bridge_peak_meter.sv | 50 +++++
 rtl/adc_sample_bridge.sv | 103 ++++++++++
 3 files changed

// File: rtl/adc_sample_bridge_pkg.sv
// adc_sample_bridge_pkg: shared audio constants, output state encoding and saturating magnitude
//   WS_DEF/SW_DEF    default ADC word and sample widths
//   FRAME_RATE       codec frame rate in Hz; PEAK_WIN_DEF is a 100 ms window at that rate
//   outState_t       EMPTY/FULL encoding of the output holding register
//   satAbs(s, w)     |s| for a w-bit two's complement value, most negative value clamps to max positive
package adc_sample_bridge_pkg;

    localparam int WS_DEF       = 32;
    localparam int SW_DEF       = 16;
    localparam int FRAME_RATE   = 48000;
    localparam int PEAK_WIN_DEF = FRAME_RATE / 10;

    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} outState_t;

    // Works on a 32-bit carrier so any sample width up to 32 can share one function.
    function automatic logic [31:0] satAbs(input logic [31:0] s, input int unsigned w);
        logic [31:0] msb, mask, v, neg;
        msb  = 32'd1 << (w - 1);
        mask = (msb << 1) - 32'd1;
        v    = s & mask;
        neg  = (~v + 32'd1) & mask;
        return ((v & msb) == 32'd0) ? v : ((v == msb) ? msb - 32'd1 : neg);
    endfunction

endpackage

// File: rtl/adc_sample_bridge_peak_meter.sv
// audio_peak_meter: per-channel peak magnitude over a window of PEAK_WIN frames
//   iCLK_50/iRST_N  clock, synchronous active-low reset
//   frameEvent      one-cycle strobe per completed frame
//   sample          signed sample valid with frameEvent
//   peak            largest magnitude of the last completed window
//   peakValid       one-cycle pulse when peak updates
module audio_peak_meter
    import adc_sample_bridge_pkg::*;
#(
    parameter int SW       = SW_DEF,
    parameter int PEAK_WIN = PEAK_WIN_DEF
) (
    input  logic          iCLK_50,
    input  logic          iRST_N,
    input  logic          frameEvent,
    input  logic [SW-1:0] sample,
    output logic [SW-2:0] peak,
    output logic          peakValid
);

    localparam int CW = (PEAK_WIN > 1) ? $clog2(PEAK_WIN) : 1;

    logic [SW-2:0] acc, mag, mx;
    logic [CW-1:0] cnt;
    logic          last;

    always_comb begin
        mag  = (SW-1)'(satAbs(32'(sample), SW));
        mx   = (mag > acc) ? mag : acc;
        last = (cnt == CW'(PEAK_WIN - 1));
    end

    // The closing frame of a window folds its own magnitude into the reported peak.
    always_ff @(posedge iCLK_50) begin
        if (!iRST_N) begin
            acc       <= '0;
            cnt       <= '0;
            peak      <= '0;
            peakValid <= 1'b0;
        end else begin
            peakValid <= frameEvent && last;
            if (frameEvent) begin
                acc  <= last ? '0 : mx;
                cnt  <= last ? '0 : cnt + 1'b1;
                peak <= last ? mx : peak;
            end
        end
    end

endmodule

// File: rtl/adc_sample_bridge.sv
// adc_sample_bridge: moves ADC stereo frames into the 50 MHz domain with valid/ready and peak metering
//   iCLK_50/iRST_N       system clock, synchronous active-low reset
//   iAUD_ADCLRCK         codec LRCK, asynchronous; its rising edge marks a complete L/R pair
//   iLData/iRData        ADC reader words; sample is the low SW bits
//   oLSample/oRSample    held stereo pair, oValid/iReady handshake
//   oOverflow/iClrOvf    sticky overwrite flag and its clear (set wins)
//   oPeakL/oPeakR        per-window peak magnitudes, oPeakValid pulses on update
module adc_sample_bridge
    import adc_sample_bridge_pkg::*;
#(
    parameter int WS       = WS_DEF,
    parameter int SW       = SW_DEF,
    parameter int PEAK_WIN = PEAK_WIN_DEF
) (
    input  logic          iCLK_50,
    input  logic          iRST_N,
    input  logic          iAUD_ADCLRCK,
    input  logic [WS-1:0] iLData,
    input  logic [WS-1:0] iRData,
    output logic [SW-1:0] oLSample,
    output logic [SW-1:0] oRSample,
    output logic          oValid,
    input  logic          iReady,
    output logic          oOverflow,
    input  logic          iClrOvf,
    output logic [SW-2:0] oPeakL,
    output logic [SW-2:0] oPeakR,
    output logic          oPeakValid
);

    logic       s1, s2, s3;
    logic [1:0] primeCnt;
    logic       frameEvent;
    logic       rPeakValid;
    logic       unusedBits;
    outState_t  state, nextState;

    // Data words are stable for microseconds around the LRCK edge, so only LRCK is synchronised.
    always_ff @(posedge iCLK_50) begin
        if (!iRST_N) begin
            s1       <= 1'b0;
            s2       <= 1'b0;
            s3       <= 1'b0;
            primeCnt <= 2'd0;
        end else begin
            s1       <= iAUD_ADCLRCK;
            s2       <= s1;
            s3       <= s2;
            primeCnt <= (primeCnt == 2'd3) ? primeCnt : primeCnt + 2'd1;
        end
    end

    // Priming hides the edge seen when LRCK is already high as the synchroniser fills after reset.
    assign frameEvent = s2 && !s3 && (primeCnt == 2'd3);

    always_ff @(posedge iCLK_50) begin
        if (!iRST_N) state <= EMPTY;
        else         state <= nextState;
    end

    // A new frame always lands; acceptance in the same cycle simply retires the old pair.
    always_comb begin
        nextState = frameEvent ? FULL : ((state == FULL) && iReady) ? EMPTY : state;
    end

    assign oValid = (state == FULL);

    always_ff @(posedge iCLK_50) begin
        if (!iRST_N) begin
            oLSample  <= '0;
            oRSample  <= '0;
            oOverflow <= 1'b0;
        end else begin
            if (frameEvent) begin
                oLSample <= iLData[SW-1:0];
                oRSample <= iRData[SW-1:0];
            end
            oOverflow <= (frameEvent && (state == FULL) && !iReady) || (oOverflow && !iClrOvf);
        end
    end

    audio_peak_meter #(.SW(SW), .PEAK_WIN(PEAK_WIN)) peakL (
        .iCLK_50   (iCLK_50),
        .iRST_N    (iRST_N),
        .frameEvent(frameEvent),
        .sample    (iLData[SW-1:0]),
        .peak      (oPeakL),
        .peakValid (oPeakValid)
    );

    // Shares frameEvent with the left meter, so its pulse is identical and not needed.
    audio_peak_meter #(.SW(SW), .PEAK_WIN(PEAK_WIN)) peakR (
        .iCLK_50   (iCLK_50),
        .iRST_N    (iRST_N),
        .frameEvent(frameEvent),
        .sample    (iRData[SW-1:0]),
        .peak      (oPeakR),
        .peakValid (rPeakValid)
    );

    assign unusedBits = ^{iLData[WS-1:SW], iRData[WS-1:SW], rPeakValid};

endmodule
